matrix_scan: RTL and testbench

MATRIX_SCAN -- requirements
Module: matrix_scan

---
 rtl/matrix_pkg.sv | 44 ++++
 rtl/matrix_row_mux.sv | 32 +++
 rtl/matrix_scan.sv | 204 ++++++++++++++++++++
 tb/tb_matrix_scan.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// ---------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the 5x7 LED matrix blocks (scanner, map decoder, ...).
//   - scan_state_e : scan FSM state encoding. BLANK is only present when the
//                    build defines MATRIX_SCAN_BLANK_EN.
//   - N_ROWS, N_COLS, PAT_W : matrix geometry (pattern is row-major, MSB first).
//   - row_decode() : row index -> active-low one-hot row select; out-of-range
//                    indices give all rows off.
// ---------------------------------------------------------------------------
package matrix_pkg;

  localparam int N_ROWS = 7;
  localparam int N_COLS = 5;
  localparam int PAT_W  = 35;

`ifdef MATRIX_SCAN_BLANK_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } scan_state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1
  } scan_state_e;
`endif

  function automatic logic [6:0] row_decode(input logic [2:0] r);
    logic [6:0] sel;
    case (r)
      3'd0:    sel = 7'h7E;
      3'd1:    sel = 7'h7D;
      3'd2:    sel = 7'h7B;
      3'd3:    sel = 7'h77;
      3'd4:    sel = 7'h6F;
      3'd5:    sel = 7'h5F;
      3'd6:    sel = 7'h3F;
      default: sel = 7'h7F;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/matrix_row_mux.sv
// ---------------------------------------------------------------------------
// matrix_row_mux
// Combinational extraction of one row of a 35-bit row-major 5x7 pattern.
// Ports:
//   i_pat [34:0] : pattern, i_pat[34] = row0/col0, i_pat[0] = row6/col4
//   i_row [2:0]  : row index 0..6 (7 gives all-zero columns)
//   o_col [4:0]  : column bits of that row, o_col[4] = col0
// ---------------------------------------------------------------------------
module matrix_row_mux
  import matrix_pkg::*;
(
  input  logic [PAT_W-1:0]  i_pat,
  input  logic [2:0]        i_row,
  output logic [N_COLS-1:0] o_col
);

  // Row select: fixed slices keep the mux shallow and width-exact.
  always_comb begin
    o_col = 5'd0;
    case (i_row)
      3'd0:    o_col = i_pat[34:30];
      3'd1:    o_col = i_pat[29:25];
      3'd2:    o_col = i_pat[24:20];
      3'd3:    o_col = i_pat[19:15];
      3'd4:    o_col = i_pat[14:10];
      3'd5:    o_col = i_pat[9:5];
      3'd6:    o_col = i_pat[4:0];
      default: o_col = 5'd0;
    endcase
  end

endmodule

// File: rtl/matrix_scan.sv
// ---------------------------------------------------------------------------
// matrix_scan
// Row-multiplexed scanner for a 5x7 LED matrix with a double-buffered pattern.
// A pattern loaded with `load` is held in a pending register and promoted to
// the displayed (shadow) register only at a frame start, so a frame is never
// torn. Each row is driven for DIV cycles; rows run 0..6 and wrap.
// Optional build macro: MATRIX_SCAN_BLANK_EN inserts BLANK_CYC dead cycles
// (all rows off) after every row.
// Parameters:
//   DIV       : cycles each row is held active (>= 2)
//   BLANK_CYC : dead-time cycles between rows when blanking is built (>= 1)
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   M     : 35-bit pattern, M[34] = row0/col0
//   load  : one-cycle strobe, capture M into pending
//   en    : scanning enabled (level)
//   ROW   : active-low one-hot row select (registered)
//   COL   : active-high column data (registered), COL[4] = col0
//   FRAME : one-cycle pulse on the last active cycle of row 6 (registered)
// ---------------------------------------------------------------------------
module matrix_scan
  import matrix_pkg::*;
#(
  parameter int DIV       = 1000,
  parameter int BLANK_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PAT_W-1:0]  M,
  input  logic              load,
  input  logic              en,
  output logic [N_ROWS-1:0] ROW,
  output logic [N_COLS-1:0] COL,
  output logic              FRAME
);

  localparam int              PRE_W    = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  // Elaboration-time parameter legality.
  if (DIV < 2) begin : g_bad_div
    $error("matrix_scan: DIV must be >= 2");
  end
  if (BLANK_CYC < 1) begin : g_bad_blank
    $error("matrix_scan: BLANK_CYC must be >= 1");
  end

  scan_state_e      r_state;
  logic [2:0]       r_row;
  logic [PRE_W-1:0] r_pre;
  logic [PAT_W-1:0] r_pend;
  logic             r_pend_valid;
  logic [PAT_W-1:0] r_shadow;

  scan_state_e      w_state_nxt;
  logic [2:0]       w_row_nxt;
  logic [PRE_W-1:0] w_pre_nxt;
  logic             w_frame_start;
  logic [PAT_W-1:0] w_shadow_nxt;
  logic [N_COLS-1:0] w_col_nxt;
  logic             w_scan_nxt;

`ifdef MATRIX_SCAN_BLANK_EN
  localparam int              BLK_W    = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYC - 1);
  logic [BLK_W-1:0] r_blk;
  logic [BLK_W-1:0] w_blk_nxt;
`endif

  // Next-state: row/prescaler sequencing and frame-start detection.
  always_comb begin
    w_state_nxt   = r_state;
    w_row_nxt     = r_row;
    w_pre_nxt     = r_pre;
    w_frame_start = 1'b0;
`ifdef MATRIX_SCAN_BLANK_EN
    w_blk_nxt     = r_blk;
`endif
    case (r_state)
      IDLE: begin
        w_row_nxt = 3'd0;
        w_pre_nxt = '0;
`ifdef MATRIX_SCAN_BLANK_EN
        w_blk_nxt = '0;
`endif
        if (en) begin
          w_state_nxt   = SCAN;
          w_frame_start = 1'b1;
        end else begin
          w_state_nxt   = IDLE;
        end
      end
      SCAN: begin
        if (!en) begin
          w_state_nxt = IDLE;
          w_row_nxt   = 3'd0;
          w_pre_nxt   = '0;
        end else if (r_pre == PRE_LAST) begin
          w_pre_nxt = '0;
`ifdef MATRIX_SCAN_BLANK_EN
          // Row advance is deferred until the dead time has elapsed.
          w_state_nxt = BLANK;
          w_blk_nxt   = '0;
`else
          if (r_row == 3'd6) begin
            w_row_nxt     = 3'd0;
            w_frame_start = 1'b1;
          end else begin
            w_row_nxt     = r_row + 3'd1;
          end
`endif
        end else begin
          w_pre_nxt = r_pre + PRE_W'(1);
        end
      end
`ifdef MATRIX_SCAN_BLANK_EN
      BLANK: begin
        if (!en) begin
          w_state_nxt = IDLE;
          w_row_nxt   = 3'd0;
          w_pre_nxt   = '0;
          w_blk_nxt   = '0;
        end else if (r_blk == BLK_LAST) begin
          w_state_nxt = SCAN;
          w_blk_nxt   = '0;
          if (r_row == 3'd6) begin
            w_row_nxt     = 3'd0;
            w_frame_start = 1'b1;
          end else begin
            w_row_nxt     = r_row + 3'd1;
          end
        end else begin
          w_blk_nxt = r_blk + BLK_W'(1);
        end
      end
`endif
      default: begin
        w_state_nxt = IDLE;
        w_row_nxt   = 3'd0;
        w_pre_nxt   = '0;
      end
    endcase
  end

  // Shadow is promoted at frame start so the very first row of the new
  // frame already shows the new pattern.
  always_comb begin
    w_shadow_nxt = r_shadow;
    w_scan_nxt   = (w_state_nxt == SCAN);
    if (w_frame_start && r_pend_valid) begin
      w_shadow_nxt = r_pend;
    end else begin
      w_shadow_nxt = r_shadow;
    end
  end

  matrix_row_mux u_row_mux (
    .i_pat (w_shadow_nxt),
    .i_row (w_row_nxt),
    .o_col (w_col_nxt)
  );

  // State, buffers and outputs. Outputs are registered from next-state values
  // so they are valid in the same cycle the FSM enters a row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_row        <= 3'd0;
      r_pre        <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_shadow     <= '0;
      ROW          <= 7'h7F;
      COL          <= 5'd0;
      FRAME        <= 1'b0;
`ifdef MATRIX_SCAN_BLANK_EN
      r_blk        <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_row    <= w_row_nxt;
      r_pre    <= w_pre_nxt;
      r_shadow <= w_shadow_nxt;
`ifdef MATRIX_SCAN_BLANK_EN
      r_blk    <= w_blk_nxt;
`endif
      // A load on a frame start wins the valid flag: old pending has just
      // moved to shadow, the new value waits for the following frame.
      if (load) begin
        r_pend       <= M;
        r_pend_valid <= 1'b1;
      end else if (w_frame_start) begin
        r_pend_valid <= 1'b0;
      end else begin
        r_pend_valid <= r_pend_valid;
      end
      ROW   <= w_scan_nxt ? row_decode(w_row_nxt) : 7'h7F;
      COL   <= w_scan_nxt ? w_col_nxt : 5'd0;
      FRAME <= w_scan_nxt && (w_row_nxt == 3'd6) && (w_pre_nxt == PRE_LAST);
    end
  end

endmodule

// File: tb/tb_matrix_scan.sv
// ---------------------------------------------------------------------------
// tb_matrix_scan
// Scoreboard bench for matrix_scan (DIV = 4, BLANK_CYC = 2). The reference
// model tracks a position within the frame period and derives row/column/
// frame outputs arithmetically; expected outputs are queued per cycle and a
// separate monitor compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_matrix_scan;

  localparam int DIV       = 4;
  localparam int BLANK_CYC = 2;
`ifdef MATRIX_SCAN_BLANK_EN
  localparam int GAP = BLANK_CYC;
`else
  localparam int GAP = 0;
`endif
  localparam int SLOT   = DIV + GAP;
  localparam int PERIOD = 7 * SLOT;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [34:0] M     = 35'd0;
  logic        load  = 1'b0;
  logic        en    = 1'b0;
  logic [6:0]  ROW;
  logic [4:0]  COL;
  logic        FRAME;

  matrix_scan #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .M     (M),
    .load  (load),
    .en    (en),
    .ROW   (ROW),
    .COL   (COL),
    .FRAME (FRAME)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] row;
    logic [4:0] col;
    logic       frame;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: position in the frame plus the two pattern buffers.
  bit          m_active = 1'b0;
  int          m_t      = 0;
  logic [34:0] m_pend   = 35'd0;
  logic [34:0] m_shadow = 35'd0;
  bit          m_pv     = 1'b0;

  task automatic step(input logic r, input logic e, input logic l, input logic [34:0] m);
    bit   fs;
    int   rr;
    int   ph;
    exp_t x;
    logic [6:0]  oh;
    logic [34:0] sh;
    @(negedge clk);
    rst_n = r; en = e; load = l; M = m;
    fs = 1'b0;
    if (!r) begin
      m_active = 1'b0; m_t = 0; m_pend = 35'd0; m_shadow = 35'd0; m_pv = 1'b0;
    end else begin
      if (!m_active) begin
        if (e) begin m_active = 1'b1; m_t = 0; fs = 1'b1; end
      end else if (!e) begin
        m_active = 1'b0; m_t = 0;
      end else begin
        m_t = (m_t + 1) % PERIOD;
        if (m_t == 0) fs = 1'b1;
      end
      if (fs && m_pv) begin m_shadow = m_pend; m_pv = 1'b0; end
      if (l) begin m_pend = m; m_pv = 1'b1; end
    end
    x.row = 7'h7F; x.col = 5'd0; x.frame = 1'b0;
    if (m_active) begin
      rr = m_t / SLOT;
      ph = m_t % SLOT;
      if (ph < DIV) begin
        oh      = 7'd1 << rr;
        x.row   = ~oh;
        sh      = m_shadow >> (30 - 5 * rr);
        x.col   = sh[4:0];
        x.frame = (rr == 6) && (ph == DIV - 1);
      end
    end
    exp_q.push_back(x);
  endtask

  // Monitor: one expected entry per clock, compared just after the edge.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      checks++;
      if (ROW !== x.row) begin
        errors++;
        $display("FAIL row t=%0t got=%h exp=%h", $time, ROW, x.row);
      end
      checks++;
      if (COL !== x.col) begin
        errors++;
        $display("FAIL col t=%0t got=%b exp=%b", $time, COL, x.col);
      end
      checks++;
      if (FRAME !== x.frame) begin
        errors++;
        $display("FAIL frame t=%0t got=%b exp=%b", $time, FRAME, x.frame);
      end
    end
  end

  logic [34:0] rm;

  initial begin
    // Reset held with en high, then release: row 0 next cycle.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 35'd0);
    step(1'b1, 1'b1, 1'b0, 35'd0);
    step(1'b1, 1'b0, 1'b0, 35'd0);

    // Pattern mapping: corner pixels, loaded while idle.
    step(1'b1, 1'b0, 1'b1, 35'h400000001);
    for (int i = 0; i < PERIOD + 4; i++) step(1'b1, 1'b1, 1'b0, 35'd0);

    // Double buffering: load during row 3.
    for (int i = 0; i < 2 * PERIOD; i++) begin
      if (m_active && (m_t / SLOT) == 3) break;
      step(1'b1, 1'b1, 1'b0, 35'd0);
    end
    step(1'b1, 1'b1, 1'b1, 35'h7_5555_5555);
    for (int i = 0; i < PERIOD + 3; i++) step(1'b1, 1'b1, 1'b0, 35'd0);

    // Load coinciding with the row 6 -> row 0 boundary, with an older
    // pending value queued ahead of it.
    step(1'b1, 1'b1, 1'b1, 35'h0_F0F0_F0F0);
    for (int i = 0; i < 2 * PERIOD; i++) begin
      if (m_active && m_t == PERIOD - 1) break;
      step(1'b1, 1'b1, 1'b0, 35'd0);
    end
    step(1'b1, 1'b1, 1'b1, 35'h3_3333_3333);
    for (int i = 0; i < 2 * PERIOD + 2; i++) step(1'b1, 1'b1, 1'b0, 35'd0);

    // Disable during row 4, then restart.
    for (int i = 0; i < 2 * PERIOD; i++) begin
      if (m_active && (m_t / SLOT) == 4) break;
      step(1'b1, 1'b1, 1'b0, 35'd0);
    end
    step(1'b1, 1'b0, 1'b0, 35'd0);
    step(1'b1, 1'b0, 1'b0, 35'd0);
    for (int i = 0; i < PERIOD + 2; i++) step(1'b1, 1'b1, 1'b0, 35'd0);

    // Reset mid-frame.
    step(1'b0, 1'b1, 1'b1, 35'h1_2345_6789);
    for (int i = 0; i < SLOT + 2; i++) step(1'b1, 1'b1, 1'b0, 35'd0);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      rm = {3'($urandom_range(7, 0)), 32'($urandom)};
      step(($urandom_range(199, 0) != 0),
           ($urandom_range(39, 0) != 0),
           ($urandom_range(9, 0) == 0),
           rm);
    end

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
